// File: rtl/rle_stream_encoder.sv
// Run-length encoder: turns a valid/ready stream of signed samples into
// (symbol, run-count) pairs with count saturation and an end-of-block flush.
module rle_stream_encoder #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_last
);

   localparam logic [CNT_W-1:0] MAX_RUN = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] cur_sym;
   logic [DATA_W-1:0] pend_sym;
   logic [CNT_W-1:0]  cur_cnt;

   logic in_fire;
   logic out_free;
   logic same;
   logic sat;

   // Output register is free when empty or being drained this cycle.
   assign out_free = ~out_valid | out_ready;
   assign in_ready = (state != FLUSH) & out_free;
   assign in_fire  = in_valid & in_ready;
   assign same     = (in_data == cur_sym);
   assign sat      = (cur_cnt == MAX_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_sym   <= '0;
         cur_cnt   <= '0;
         pend_sym  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else begin
         // A load below overrides this clear when a new pair replaces the old.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (in_fire) begin
                  if (in_last) begin
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                     out_count <= ONE;
                     out_last  <= 1'b1;
                  end else begin
                     cur_sym <= in_data;
                     cur_cnt <= ONE;
                     state   <= RUN;
                  end
               end
            end

            RUN: begin
               if (in_fire) begin
                  if (same && !sat && !in_last) begin
                     cur_cnt <= cur_cnt + ONE;
                  end else if (same && sat) begin
                     out_valid <= 1'b1;
                     out_data  <= cur_sym;
                     out_count <= MAX_RUN;
                     out_last  <= 1'b0;
                     cur_cnt   <= ONE;
                     if (in_last) begin
                        pend_sym <= in_data;
                        state    <= FLUSH;
                     end
                  end else if (same) begin
                     out_valid <= 1'b1;
                     out_data  <= cur_sym;
                     out_count <= cur_cnt + ONE;
                     out_last  <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= cur_sym;
                     out_count <= cur_cnt;
                     out_last  <= 1'b0;
                     if (in_last) begin
                        pend_sym <= in_data;
                        state    <= FLUSH;
                     end else begin
                        cur_sym <= in_data;
                        cur_cnt <= ONE;
                     end
                  end
               end
            end

            FLUSH: begin
               // Emit the pending single-sample closing run once there is room.
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_data  <= pend_sym;
                  out_count <= ONE;
                  out_last  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rle_stream_encoder.md
Name: rle_stream_encoder

Overview:
- Parametrised run-length encoder for the compression path, placed after the quantised DWT coefficient stream.
- Converts a stream of signed samples into (symbol, run-count) pairs.
- Adds valid/ready handshakes on both sides, configurable symbol and count widths, run saturation, and an end-of-block flush marker.
- Successor to the fixed 8-bit free-running encoder. Unlike that block, it never drops or delays a final run.

Parameters:
- DATA_W, 8, symbol width in bits (signed).
- CNT_W, 8, run-count width in bits. MAX_RUN = 2**CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  encoder can accept a sample this cycle
- in_data  in  DATA_W  signed input sample
- in_last  in  1  sample is the last of the block; flush after it
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts the pair this cycle
- out_data  out  DATA_W  signed run symbol
- out_count  out  CNT_W  run length, 1..MAX_RUN, never 0 when out_valid=1
- out_last  out  1  pair closes the block

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, cur_sym=0, cur_cnt=0, pend_sym=0
  - out_valid=0, out_data=0, out_count=0, out_last=0
- Asserting reset mid-run discards the open run. No pair is emitted.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Output register: single entry.
  - in_ready = (state!=FLUSH) & (~out_valid | out_ready). Combinational, no dependence on in_valid.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - out_valid clears on an output transfer unless a new pair is loaded in the same cycle.
- FSM states:
  - IDLE: no open run.
  - RUN: open run (cur_sym, cur_cnt).
  - FLUSH: one pending single-sample last run.
- On an input transfer in IDLE:
  - Sets cur_sym=in_data, cur_cnt=1, goes to RUN.
  - If in_last=1: instead loads pair (in_data, 1, last=1) and stays in IDLE.
- On an input transfer in RUN, rules are evaluated in this priority order:
  1. in_data==cur_sym, cur_cnt<MAX_RUN, in_last=0: cur_cnt++. No output.
  2. in_data==cur_sym, cur_cnt==MAX_RUN: load pair (cur_sym, MAX_RUN, last=0). New run cur_cnt=1. If in_last=1, go to FLUSH with pend_sym=in_data.
  3. in_data==cur_sym, cur_cnt<MAX_RUN, in_last=1: load pair (cur_sym, cur_cnt+1, last=1). Go to IDLE.
  4. in_data!=cur_sym, in_last=0: load pair (cur_sym, cur_cnt, last=0). Start cur_sym=in_data, cur_cnt=1.
  5. in_data!=cur_sym, in_last=1: load pair (cur_sym, cur_cnt, last=0). Go to FLUSH with pend_sym=in_data.
- FLUSH:
  - in_ready=0.
  - When the output register is free, or drains this cycle, load pair (pend_sym, 1, last=1) and go to IDLE.
- Latency:
  - A pair appears on out_* in the cycle after the input transfer that terminates the run.
  - Full throughput (one sample per cycle) with out_ready held at 1.
- Loading a pair always coincides with an input transfer or FLUSH. in_ready gating guarantees the output register is free or draining at that point.
- Comparison is a full DATA_W equality. Sign does not matter for equality.
- A count never wraps; saturation at MAX_RUN splits the run into multiple pairs.
- in_last without in_valid is ignored.
- No idle-time timeout: an open run is emitted only by a differing sample, saturation, or in_last.

Test Plan:
- Run terminated by a different sample: DATA_W=8, CNT_W=8, out_ready=1. Input 5,5,5,-3,-3,7(last) -> pairs (5,3,0), (-3,2,0), (7,1,1). in_ready low exactly one cycle during FLUSH.
- Saturation split: CNT_W=3. Input 9 repeated ten times, the 10th with last -> (9,7,0), (9,3,1). No count ever equals 0 or exceeds 7.
- Saturation plus last: CNT_W=3. Input 4 repeated eight times, the 8th with last -> (4,7,0), then FLUSH emits (4,1,1).
- Back-pressure:
  - Hold out_ready=0 after the first pair of 1,2,3. in_ready must drop and out_data stay 1, count 1, until out_ready=1.
  - No samples are lost. Final pairs are (1,1,0), (2,1,0), (3,1,1) when 3 carries last.
- Single-sample block from IDLE: in_data=-128 with last -> (-128,1,1) the next cycle. State returns to IDLE. The next block starts clean.
- Reset mid-operation: feed 6,6,6, assert rst_n=0 asynchronously between edges.
  - out_valid=0 and all outputs 0 immediately.
  - After release, input 6(last) -> (6,1,1), not (6,4,1).
